// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC generation, single-outstanding imem handshake, IF/ID register
// Revision   : 1.0
// ============================================================================

package fetch_pkg;
  typedef struct packed {
    logic stall;
    logic squash;
  } stage_ctrl_t;

  typedef enum logic [1:0] {
    PLUS_4    = 2'd0,
    BRANCH    = 2'd1,
    JUMP      = 2'd2,
    EXCEPTION = 2'd3
  } pc_src_e;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  stage_ctrl_t fetch_ctrl_i,
  input  pc_src_e     pc_src_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        hz_imem_gnt_o,
  output logic        hz_imem_rvalid_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  localparam logic [1:0]  S_REQ     = 2'd0;
  localparam logic [1:0]  S_WAIT    = 2'd1;
  localparam logic [1:0]  S_DISCARD = 2'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic in_req, in_wait;
  logic redirect, gnt_eff, accept, avail, advance;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (gnt_eff && !imem_rvalid_i) begin
          state_d = redirect ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM outputs; a full hold buffer blocks new requests
  always_comb begin
    in_req     = (state_q == S_REQ);
    in_wait    = (state_q == S_WAIT);
    imem_req_o = in_req && !hold_valid_q && rst_ni;
  end

  // A grant only counts when we were actually requesting
  always_comb begin
    redirect = (pc_src_i != PLUS_4);
    gnt_eff  = imem_gnt_i && imem_req_o;
    accept   = (gnt_eff && imem_rvalid_i) || (in_wait && imem_rvalid_i);
    avail    = hold_valid_q || (accept && !redirect);
    advance  = avail && !fetch_ctrl_i.stall && !redirect;
  end

  always_comb begin
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (redirect) begin
      pc_d         = branch_target_i & WORD_MASK;
      hold_valid_d = 1'b0;
    end else if (advance) begin
      pc_d         = pc_q + 32'd4;
      hold_valid_d = 1'b0;
    end else if (accept && fetch_ctrl_i.stall) begin
      hold_valid_d = 1'b1;
      hold_data_d  = imem_rdata_i;
    end
  end

  always_comb begin
    if_valid_d = 1'b0;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (fetch_ctrl_i.squash) begin
      if_valid_d = 1'b0;
    end else if (fetch_ctrl_i.stall) begin
      if_valid_d = if_valid_q;
    end else if (advance) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_instr_d = hold_valid_q ? hold_data_q : imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= BOOT_ADDR & WORD_MASK;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 32'h0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0;
      if_instr_q   <= NOP_INSTR;
    end else begin
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign hz_imem_gnt_o    = avail;
  assign hz_imem_rvalid_o = avail;
  assign if_valid_o       = if_valid_q;
  assign if_pc_o          = if_pc_q;
  assign if_instr_o       = if_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector table, corner sequences and a randomized run
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  stage_ctrl_t fetch_ctrl_i;
  pc_src_e     pc_src_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        hz_imem_gnt_o;
  logic        hz_imem_rvalid_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .fetch_ctrl_i    (fetch_ctrl_i),
    .pc_src_i        (pc_src_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .hz_imem_gnt_o   (hz_imem_gnt_o),
    .hz_imem_rvalid_o(hz_imem_rvalid_o),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall;
    logic        squash;
    pc_src_e     src;
    logic [31:0] tgt;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_hz;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sq, input pc_src_e src,
                              input logic [31:0] tgt, input logic g, input logic rv,
                              input logic [31:0] rd, input logic er, input logic [31:0] ea,
                              input logic eh, input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei);
    vec_t v;
    v.stall = st; v.squash = sq; v.src = src; v.tgt = tgt;
    v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_hz = eh;
    v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  // Memory image used by the randomized phase
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input logic st, input logic sq, input pc_src_e src,
                       input logic [31:0] tgt, input logic g, input logic rv,
                       input logic [31:0] rd);
    @(negedge clk_i);
    fetch_ctrl_i.stall  = st;
    fetch_ctrl_i.squash = sq;
    pc_src_i            = src;
    branch_target_i     = tgt;
    imem_gnt_i          = g;
    imem_rvalid_i       = rv;
    imem_rdata_i        = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[13];

  // Reference-model state for the randomized phase
  bit          m_busy, m_drop, m_hv, m_valid;
  logic [31:0] m_pc, m_hd, m_ipc, m_ii, m_txn_addr;

  initial begin
    logic [31:0] d;
    rst_ni = 1'b0;
    fetch_ctrl_i = '0;
    pc_src_i = PLUS_4;
    branch_target_i = '0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    #12;
    chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr",  imem_addr_o, 32'h0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_pc",    if_pc_o, 32'h0);
    chk("rst_instr", if_instr_o, 32'h13);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vectors applied back to back starting right after reset release
    tbl[0]  = mk(0,0,PLUS_4,0,1,1,32'hA000_0000, 1,32'h0,   1, 1,32'h0,   32'hA000_0000);
    tbl[1]  = mk(0,0,PLUS_4,0,1,1,32'hA000_0001, 1,32'h4,   1, 1,32'h4,   32'hA000_0001);
    tbl[2]  = mk(0,0,PLUS_4,0,1,1,32'hA000_0002, 1,32'h8,   1, 1,32'h8,   32'hA000_0002);
    tbl[3]  = mk(0,0,PLUS_4,0,0,0,32'hDEAD_0000, 1,32'hC,   0, 0,32'h8,   32'hA000_0002);
    tbl[4]  = mk(0,0,PLUS_4,0,1,0,32'hDEAD_0001, 1,32'hC,   0, 0,32'h8,   32'hA000_0002);
    tbl[5]  = mk(0,0,PLUS_4,0,0,0,32'hDEAD_0002, 0,32'hC,   0, 0,32'h8,   32'hA000_0002);
    tbl[6]  = mk(1,0,PLUS_4,0,0,1,32'hA000_0003, 0,32'hC,   1, 0,32'h8,   32'hA000_0002);
    tbl[7]  = mk(1,0,PLUS_4,0,0,0,32'hDEAD_0003, 0,32'hC,   1, 0,32'h8,   32'hA000_0002);
    tbl[8]  = mk(0,0,PLUS_4,0,0,0,32'hDEAD_0004, 0,32'hC,   1, 1,32'hC,   32'hA000_0003);
    tbl[9]  = mk(0,0,BRANCH,32'h0000_1002,1,1,32'hDEAD_0005, 1,32'h10, 0, 0,32'hC, 32'hA000_0003);
    tbl[10] = mk(0,0,PLUS_4,0,1,1,32'hA000_0004, 1,32'h1000, 1, 1,32'h1000, 32'hA000_0004);
    tbl[11] = mk(1,1,PLUS_4,0,1,1,32'hA000_0005, 1,32'h1004, 1, 0,32'h1000, 32'hA000_0004);
    tbl[12] = mk(0,0,PLUS_4,0,0,0,32'hDEAD_0006, 0,32'h1004, 1, 1,32'h1004, 32'hA000_0005);

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].squash, tbl[i].src, tbl[i].tgt,
            tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
      chk($sformatf("v%0d_req", i),  {31'd0, imem_req_o}, {31'd0, tbl[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d_hz", i),   {30'd0, hz_imem_gnt_o, hz_imem_rvalid_o},
                                     {30'd0, tbl[i].e_hz, tbl[i].e_hz});
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, if_valid_o}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_pc", i),    if_pc_o, tbl[i].e_pc);
      chk($sformatf("v%0d_instr", i), if_instr_o, tbl[i].e_instr);
    end

    // Long-latency response: grant now, data three cycles later
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, PLUS_4, 0, c == 0, c == 3, (c == 3) ? 32'hB000_0000 : 32'hDEAD_0010);
      chk($sformatf("lat_c%0d_hz", c), {31'd0, hz_imem_gnt_o}, {31'd0, c == 3});
      chk($sformatf("lat_c%0d_req", c), {31'd0, imem_req_o}, {31'd0, c == 0});
      tick();
    end
    chk("lat_valid", {31'd0, if_valid_o}, 32'd1);
    chk("lat_pc",    if_pc_o, 32'h1008);
    chk("lat_instr", if_instr_o, 32'hB000_0000);

    // Redirect while waiting: the outstanding response must be dropped
    drive(0, 0, PLUS_4, 0, 1, 0, 32'hDEAD_0020);
    tick();
    drive(0, 0, BRANCH, 32'h0000_1002, 0, 0, 32'hDEAD_0021);
    chk("disc_req0", {31'd0, imem_req_o}, 32'd0);
    tick();
    drive(0, 0, PLUS_4, 0, 0, 1, 32'hDEAD_0022);
    chk("disc_hz", {31'd0, hz_imem_gnt_o}, 32'd0);
    chk("disc_req1", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("disc_valid", {31'd0, if_valid_o}, 32'd0);
    drive(0, 0, PLUS_4, 0, 1, 1, 32'hB000_0001);
    chk("disc_req2", {31'd0, imem_req_o}, 32'd1);
    chk("disc_addr", imem_addr_o, 32'h1000);
    tick();
    chk("disc_pc",    if_pc_o, 32'h1000);
    chk("disc_instr", if_instr_o, 32'hB000_0001);

    // PC wrap from the top of the address space
    drive(0, 0, JUMP, 32'hFFFF_FFFF, 0, 0, 32'hDEAD_0030);
    tick();
    drive(0, 0, PLUS_4, 0, 1, 1, 32'hB000_0002);
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
    drive(0, 0, PLUS_4, 0, 1, 1, 32'hB000_0003);
    chk("wrap_addr1", imem_addr_o, 32'h0);
    tick();
    chk("wrap_valid", {31'd0, if_valid_o}, 32'd1);

    // Squash together with stall clears the IF/ID valid bit
    drive(1, 1, PLUS_4, 0, 0, 0, 32'hDEAD_0040);
    tick();
    chk("sqst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("sqst_pc", if_pc_o, 32'h0);

    // Reset with a response in flight; the late rvalid is ignored
    drive(0, 0, PLUS_4, 0, 1, 0, 32'hDEAD_0050);
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_req",   {31'd0, imem_req_o}, 32'd0);
    chk("arst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("arst_instr", if_instr_o, 32'h13);
    chk("arst_addr",  imem_addr_o, 32'h0);
    drive(0, 0, PLUS_4, 0, 0, 0, 32'h0);
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, PLUS_4, 0, 0, 1, 32'hDEAD_0051);
    chk("late_hz",  {31'd0, hz_imem_gnt_o}, 32'd0);
    chk("late_req", {31'd0, imem_req_o}, 32'd1);
    tick();
    chk("late_valid", {31'd0, if_valid_o}, 32'd0);
    chk("late_instr", if_instr_o, 32'h13);

    // Randomized run against the transaction-level model
    m_busy = 0; m_drop = 0; m_hv = 0; m_hd = 0;
    m_pc = 0; m_valid = 0; m_ipc = 0; m_ii = 32'h13; m_txn_addr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic st, sq, redir, g, rv, acc, av, adv, exp_req;
      pc_src_e src;
      logic [31:0] tgt, rd;
      st    = ($urandom_range(0, 3) == 0);
      sq    = ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 9) == 0);
      src   = redir ? pc_src_e'($urandom_range(1, 3)) : PLUS_4;
      tgt   = $urandom;
      exp_req = !m_busy && !m_hv;
      g  = exp_req ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (m_busy)  rv = ($urandom_range(0, 2) == 0);
      else if (g)  rv = ($urandom_range(0, 1) == 1);
      else         rv = ($urandom_range(0, 7) == 0);
      if (m_busy)  rd = mem(m_txn_addr);
      else if (g)  rd = mem(m_pc);
      else         rd = $urandom;

      acc = (!m_busy && g && rv) || (m_busy && !m_drop && rv);
      av  = m_hv || (acc && !redir);
      adv = av && !st && !redir;
      drive(st, sq, src, tgt, g, rv, rd);
      chk("rnd_req",  {31'd0, imem_req_o}, {31'd0, exp_req});
      chk("rnd_addr", imem_addr_o, m_pc);
      chk("rnd_hz",   {30'd0, hz_imem_gnt_o, hz_imem_rvalid_o}, {30'd0, av, av});

      d = m_hv ? m_hd : rd;
      if (sq) m_valid = 0;
      else if (!st) begin
        if (adv) begin m_valid = 1; m_ipc = m_pc; m_ii = d; end
        else m_valid = 0;
      end
      if (m_busy) begin
        if (rv) begin m_busy = 0; m_drop = 0; end
        else if (redir) m_drop = 1;
      end else if (g && !rv) begin
        m_busy = 1; m_drop = redir; m_txn_addr = m_pc;
      end
      if (redir) begin m_pc = tgt & 32'hFFFF_FFFC; m_hv = 0; end
      else if (adv) begin m_pc = m_pc + 32'd4; m_hv = 0; end
      else if (acc && st) begin m_hv = 1; m_hd = rd; end

      tick();
      chk("rnd_valid", {31'd0, if_valid_o}, {31'd0, m_valid});
      chk("rnd_pc",    if_pc_o, m_ipc);
      chk("rnd_instr", if_instr_o, m_ii);
      if (if_valid_o) chk("rnd_image", if_instr_o, mem(if_pc_o));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
